// File: rtl/file_module.sv
// Single-port register file for the blur datapath: write-first on load,
// registered read data, whole array cleared asynchronously on reset.
module file_module #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;

  // Extra MSB keeps the compare meaningful when DEPTH == 2**ADDR_W.
  assign in_range = ({1'b0, address} < DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '{default: '0};
      dout <= '0;
    end else if (trigger) begin
      if (in_range) mem[address] <= din;
      dout <= din;
    end else begin
      dout <= in_range ? mem[address] : '0;
    end
  end

endmodule

// File: tb/tb_file_module.sv
// Scoreboard bench for file_module: the driver pushes expected dout per access,
// a monitor pops and compares one cycle later.
module tb_file_module;

  localparam int WIDTH = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              trigger = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [WIDTH-1:0]  din = '0;
  logic [WIDTH-1:0]  dout;

  int n_checks = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] exp_q [$];
  string            tag_q [$];
  logic [WIDTH-1:0] model [DEPTH];

  file_module #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger),
    .address(address), .din(din), .dout(dout)
  );

  always #5 clk = ~clk;

  // Monitor: each rising edge produces exactly one expected dout.
  initial begin
    logic [WIDTH-1:0] e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        if (dout !== e) begin
          n_fail++;
          $display("FAIL %s: dout=%h expected=%h", t, dout, e);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One access per call; the reference model is a plain array.
  task automatic access(input logic trig, input int addr, input logic [WIDTH-1:0] data,
                        input string tag);
    @(negedge clk);
    trigger = trig;
    address = addr[ADDR_W-1:0];
    din = data;
    if (trig) begin
      if (addr < DEPTH) model[addr] = data;
      exp_q.push_back(data);
    end else begin
      exp_q.push_back(addr < DEPTH ? model[addr] : '0);
    end
    tag_q.push_back(tag);
  endtask

  task automatic direct_check(input logic [WIDTH-1:0] exp, input string tag);
    n_checks++;
    if (dout !== exp) begin
      n_fail++;
      $display("FAIL %s: dout=%h expected=%h", tag, dout, exp);
    end
  endtask

  initial begin
    int a;
    clear_model();

    // Reset with a read pending
    repeat (3) @(posedge clk);
    #2;
    direct_check('0, "reset_dout");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) access(1'b0, k, 32'h5555_5555, "reset_read");

    // Load then read
    for (int k = 0; k < DEPTH; k++) access(1'b1, k, 32'hA000_0000 + k, "load_write");
    access(1'b0, 1, '0, "read_1");
    access(1'b0, 2, '0, "read_2");
    access(1'b0, 3, '0, "read_3");
    access(1'b0, 4, '0, "read_4");
    access(1'b0, 5, '0, "read_5");
    access(1'b0, 25, '0, "read_25");

    // Write-first, then read-back of same address
    access(1'b1, 7, 32'hDEAD_BEEF, "write_first");
    access(1'b0, 7, 32'hDEAD_BEEF, "read_after_write");

    // Read ignores din
    access(1'b0, 3, 32'hFFFF_FFFF, "read_ignores_din");
    access(1'b0, 3, 32'hFFFF_FFFF, "read_hold");
    access(1'b0, 2, 32'hFFFF_FFFF, "mem_unchanged");

    // Async reset mid-read
    access(1'b0, 25, '0, "pre_reset_read");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    direct_check('0, "async_reset_dout");
    rst_n = 1'b1;
    clear_model();
    access(1'b0, 25, '0, "post_reset_read_25");
    access(1'b0, 7, '0, "post_reset_read_7");

    // Back-to-back write/read
    for (int k = 0; k < 4; k++) begin
      access(1'b1, 0, 32'h1234_5678 + k, "b2b_write");
      access(1'b0, 0, 32'h0BAD_0BAD, "b2b_read");
    end

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      a = $urandom_range(DEPTH - 1, 0);
      access(1'($urandom_range(1, 0)), a, $urandom, "random");
    end
    for (int k = 0; k < DEPTH; k++) access(1'b0, k, $urandom, "final_sweep");

    // Drain the scoreboard with a bounded wait
    @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
